// File: rtl/magic_nor_engine.sv
// MAGIC crossbar-row NOR evaluator: runs a loadable NOR/OUT/NOP/HALT micro-program over a cell row.
// Optional MAGIC_NOR_CYCCNT_EN adds a saturating 16-bit busy-cycle counter port cyc_cnt.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; program memory writable
// LOAD   | inputs copied into low cells, other cells cleared, pc reset
// EXEC   | fetch mem[pc]; NOR does INIT (dst=1), NOP/OUT complete here
// EVAL   | NOR evaluation into dst, advance pc
// FIN    | one-cycle done pulse
module magic_nor_engine #(
   parameter int NUM_IN     = 8,
   parameter int NUM_CELLS  = 32,
   parameter int NUM_OUT    = 4,
   parameter int PROG_DEPTH = 32,
   localparam int CW = $clog2(NUM_CELLS),
   localparam int IW = 4 + 4*CW,
   localparam int PW = $clog2(PROG_DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we,
   input  logic [PW-1:0]      prog_addr,
   input  logic [IW-1:0]      prog_wdata,
   input  logic               start,
   input  logic [NUM_IN-1:0]  x,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [NUM_OUT-1:0] z
`ifdef MAGIC_NOR_CYCCNT_EN
   ,
   output logic [15:0]        cyc_cnt
`endif
);

   localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_NOR  = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;
   localparam logic [1:0] OP_OUT  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_EVAL, S_FIN} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        mem [PROG_DEPTH];
   logic [PW-1:0]        pc;
   logic [NUM_CELLS-1:0] cells;

   logic [IW-1:0] ins;
   logic [1:0]    op, n;
   logic [CW-1:0] dst, a, b, c;
   logic [OW-1:0] z_idx;
   logic          last_pc;
   logic          nor_res;

   assign ins     = mem[pc];
   assign op      = ins[IW-1 -: 2];
   assign n       = ins[IW-3 -: 2];
   assign dst     = ins[4*CW-1 -: CW];
   assign a       = ins[3*CW-1 -: CW];
   assign b       = ins[2*CW-1 -: CW];
   assign c       = ins[CW-1:0];
   assign z_idx   = OW'(32'(dst) % NUM_OUT);
   assign last_pc = (pc == PW'(PROG_DEPTH-1));

   // dst already holds 1 from INIT, so a self-referencing operand forces 0
   assign nor_res = ~(cells[a] | ((n >= 2'd2) & cells[b]) | ((n == 2'd3) & cells[c]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_LOAD;
         S_LOAD: begin
            busy    = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            busy = 1'b1;
            case (op)
               OP_HALT: state_d = S_FIN;
               OP_NOR:  state_d = S_EVAL;
               default: if (last_pc) state_d = S_FIN;
            endcase
         end
         S_EVAL: begin
            busy    = 1'b1;
            state_d = last_pc ? S_FIN : S_EXEC;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // program memory is deliberately not reset so it survives a mid-run reset
   always_ff @(posedge clk) begin
      if (prog_we && state_q == S_IDLE) mem[prog_addr] <= prog_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= '0;
         cells <= '0;
         err   <= 1'b0;
         z     <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) err <= 1'b0;
            S_LOAD: begin
               cells <= NUM_CELLS'(x);
               pc    <= '0;
            end
            S_EXEC: begin
               if (op == OP_NOR) begin
                  cells[dst] <= 1'b1;
               end else if (op != OP_HALT) begin
                  if (op == OP_OUT) z[z_idx] <= cells[a];
                  if (last_pc) err <= 1'b1;
                  else         pc  <= pc + PW'(1);
               end
            end
            S_EVAL: begin
               cells[dst] <= nor_res;
               if (last_pc) err <= 1'b1;
               else         pc  <= pc + PW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef MAGIC_NOR_CYCCNT_EN
   // LOAD counts as the first busy cycle; value holds from FIN until the next LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cyc_cnt <= '0;
      else if (state_q == S_LOAD)
         cyc_cnt <= 16'd1;
      else if ((state_q == S_EXEC || state_q == S_EVAL) && cyc_cnt != 16'hFFFF)
         cyc_cnt <= cyc_cnt + 16'd1;
   end
`endif

endmodule
